change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Downstream of the soda vending FSM; consumes its release_soda and change[2:0] outputs at the moment the customer presses the button.
- Drives the soda actuator, then pays change from nickel and dime hoppers using a four-phase req/ack handshake per actuator.
- Handles ack timeouts, hopper-empty sensors and invalid change codes via a sticky fault state.

Parameters:
- TIMEOUT, 1000, max cycles to wait for an ack edge (rise after req, or fall after req drop) before faulting.
- MIN_GAP, 2, idle cycles forced between consecutive actuator requests (≥1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- release_soda  in  1  from vending FSM; high while ≥30 cents is credited.
- change  in  3  from vending FSM; change owed in nickels (0..4 valid; 5..7 invalid).
- button_press  in  1  customer button; same signal the vending FSM consumes.
- soda_req  out  1  soda actuator request.
- soda_ack  in  1  soda actuator acknowledge.
- coin_req  out  1  coin hopper request.
- coin_sel  out  1  0 = nickel, 1 = dime; stable for the whole time coin_req is high.
- coin_ack  in  1  coin hopper acknowledge.
- nickel_empty  in  1  nickel hopper empty sensor.
- dime_empty  in  1  dime hopper empty sensor.
- busy  out  1  vend in progress (any state except IDLE).
- fault  out  1  high in FAULT.
- fault_code  out  2  0 none, 1 ack timeout, 2 cannot make change, 3 bad change code.
- overrun  out  1  sticky; set by a vend trigger arriving while not in IDLE.
- fault_clear  in  1  returns FAULT to IDLE; clears fault_code and overrun.

Behaviour:
- Reset: state IDLE; all outputs 0; remaining = 0; counters 0.
- Vend trigger = release_soda & button_press, sampled at posedge. This is the last cycle the vending FSM shows valid change, so change is captured into a 3-bit remaining register on that edge.
- IDLE → SODA_REQ on trigger with change ≤ 4.
- IDLE → FAULT (code 3) on trigger with change ≥ 5; the soda is not released.
- A trigger in any non-IDLE state is ignored and sets overrun; the in-progress vend continues unaffected.
- SODA_REQ: soda_req = 1 until soda_ack is sampled high; then → SODA_REL with soda_req = 0.
- SODA_REL: wait for soda_ack = 0, then → GAP.
- GAP: count MIN_GAP cycles, then evaluate:
  - remaining = 0 → IDLE.
  - remaining ≥ 2 and !dime_empty → COIN_REQ with coin_sel = 1; decrement remaining by 2.
  - remaining ≥ 1 and !nickel_empty → COIN_REQ with coin_sel = 0; decrement remaining by 1.
  - otherwise → FAULT (code 2).
  - Dime is preferred whenever the dime rule applies.
- Decrement timing: remaining is decremented on entry to COIN_REQ. It is registered and never underflows.
- COIN_REQ / COIN_REL mirror SODA_REQ / SODA_REL on coin_req / coin_ack; COIN_REL → GAP.
- Timeout: a single counter resets on every state entry and increments in SODA_REQ, SODA_REL, COIN_REQ and COIN_REL. On reaching TIMEOUT → FAULT (code 1), with all reqs dropped in the same transition.
- FAULT:
  - soda_req and coin_req are 0; fault = 1; fault_code is held.
  - fault_clear → IDLE. Triggers arriving while in FAULT set overrun.
  - fault_clear in any other state clears overrun only.
- Outputs are registered. Requests rise one cycle after the deciding edge and fall on the edge after ack is sampled high. Ack asserted in the same cycle req rises is legal.
- Reset mid-vend aborts immediately: reqs drop asynchronously and any remaining change is lost.

Decomposition:
- Shared package holds:
  - the dispenser state enum (IDLE, SODA_REQ, SODA_REL, GAP, COIN_REQ, COIN_REL, FAULT);
  - the fault_code enum;
  - the coin_sel constants NICKEL_SEL = 0 and DIME_SEL = 1;
  - the nickel-unit change constant MAX_CHANGE = 4.
- One sub-module, req_ack_timer: holds one req/ack four-phase handshake plus the timeout counter, reporting done and timed_out. It is instantiated once and shared between the soda and coin phases, because only one phase is active at a time.

Test Plan:
- Reset mid-COIN_REQ → reqs drop immediately; state IDLE; busy = 0; remaining lost.
- change = 3, both hoppers full, acks after 3 cycles → soda pulse, then dime, then nickel; each request separated by 2 idle cycles; busy drops after the last ack falls; fault = 0.
- change = 4, dime_empty = 1 → soda pulse followed by four nickel requests (coin_sel = 0 each time).
- change = 1, nickel_empty = 1 → soda pulse, then FAULT with fault_code = 2; fault_clear → IDLE.
- soda_ack held low for TIMEOUT cycles → FAULT with code 1, soda_req = 0; a second trigger during FAULT → overrun = 1; fault_clear clears both.
- change = 5 with trigger → FAULT with code 3, soda_req never asserted.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: dispenser states,
// fault codes, coin selector values and the largest valid change amount.
package change_dispenser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SODA_REQ,
        SODA_REL,
        GAP,
        COIN_REQ,
        COIN_REL,
        FAULT
    } disp_state_t;

    typedef enum logic [1:0] {
        FC_NONE      = 2'd0,
        FC_TIMEOUT   = 2'd1,
        FC_NO_CHANGE = 2'd2,
        FC_BAD_CODE  = 2'd3
    } fault_code_t;

    localparam logic NICKEL_SEL = 1'b0;
    localparam logic DIME_SEL   = 1'b1;

    // Change is counted in nickels.
    localparam logic [2:0] MAX_CHANGE = 3'd4;

endpackage

// File: rtl/change_dispenser_timer.sv
// Tracks one four-phase req/ack handshake (ack rise while requesting, ack fall
// after release) and the cycle budget allowed for each of those two waits.
module req_ack_timer #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic req_phase,
    input  logic rel_phase,
    input  logic ack,
    output logic done,
    output logic timed_out
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;
    logic          active;

    always_comb begin
        active    = req_phase || rel_phase;
        done      = (req_phase && ack) || (rel_phase && !ack);
        // The wait is abandoned before count can pass TIMEOUT-1, so no wrap.
        timed_out = active && !done && (count == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (active) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: releases the soda, then pays owed change from the dime and
// nickel hoppers over req/ack handshakes, parking in a sticky fault on errors.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned MIN_GAP = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       release_soda,
    input  logic [2:0] change,
    input  logic       button_press,
    output logic       soda_req,
    input  logic       soda_ack,
    output logic       coin_req,
    output logic       coin_sel,
    input  logic       coin_ack,
    input  logic       nickel_empty,
    input  logic       dime_empty,
    output logic       busy,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       overrun,
    input  logic       fault_clear
);

    localparam int unsigned GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    disp_state_t      state, state_n;
    fault_code_t      code_q, code_n;
    logic [2:0]       remaining, remaining_n;
    logic [GAP_W-1:0] gap_cnt;
    logic             sel_n, overrun_n;
    logic             trigger, restart, gap_done;
    logic             req_phase, rel_phase, hs_ack, hs_done, hs_timeout;

    always_comb begin
        trigger   = release_soda && button_press;
        req_phase = (state == SODA_REQ) || (state == COIN_REQ);
        rel_phase = (state == SODA_REL) || (state == COIN_REL);
        hs_ack    = ((state == SODA_REQ) || (state == SODA_REL)) ? soda_ack : coin_ack;
        gap_done  = (gap_cnt == GAP_W'(MIN_GAP - 1));
    end

    req_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .restart   (restart),
        .req_phase (req_phase),
        .rel_phase (rel_phase),
        .ack       (hs_ack),
        .done      (hs_done),
        .timed_out (hs_timeout)
    );

    always_comb begin
        state_n     = state;
        code_n      = code_q;
        remaining_n = remaining;
        sel_n       = coin_sel;
        case (state)
            IDLE: begin
                if (trigger) begin
                    if (change > MAX_CHANGE) begin
                        state_n = FAULT;
                        code_n  = FC_BAD_CODE;
                    end else begin
                        state_n     = SODA_REQ;
                        remaining_n = change;
                    end
                end
            end
            SODA_REQ, COIN_REQ, SODA_REL, COIN_REL: begin
                if (hs_done) begin
                    case (state)
                        SODA_REQ: state_n = SODA_REL;
                        COIN_REQ: state_n = COIN_REL;
                        default:  state_n = GAP;
                    endcase
                end else if (hs_timeout) begin
                    state_n = FAULT;
                    code_n  = FC_TIMEOUT;
                end
            end
            GAP: begin
                if (gap_done) begin
                    if (remaining == 3'd0) begin
                        state_n = IDLE;
                    end else if (remaining >= 3'd2 && !dime_empty) begin
                        state_n     = COIN_REQ;
                        sel_n       = DIME_SEL;
                        remaining_n = remaining - 3'd2;
                    end else if (!nickel_empty) begin
                        state_n     = COIN_REQ;
                        sel_n       = NICKEL_SEL;
                        remaining_n = remaining - 3'd1;
                    end else begin
                        state_n = FAULT;
                        code_n  = FC_NO_CHANGE;
                    end
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    state_n = IDLE;
                    code_n  = FC_NONE;
                end
            end
            default: state_n = IDLE;
        endcase

        restart = (state_n != state);

        overrun_n = overrun;
        if (trigger && state != IDLE) begin
            overrun_n = 1'b1;
        end else if (fault_clear) begin
            overrun_n = 1'b0;
        end
    end

    // Outputs are registered from the next state so they change with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            code_q    <= FC_NONE;
            remaining <= '0;
            gap_cnt   <= '0;
            soda_req  <= 1'b0;
            coin_req  <= 1'b0;
            coin_sel  <= NICKEL_SEL;
            busy      <= 1'b0;
            fault     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            code_q    <= code_n;
            remaining <= remaining_n;
            if (restart) begin
                gap_cnt <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
            soda_req  <= (state_n == SODA_REQ);
            coin_req  <= (state_n == COIN_REQ);
            coin_sel  <= sel_n;
            busy      <= (state_n != IDLE);
            fault     <= (state_n == FAULT);
            overrun   <= overrun_n;
        end
    end

    assign fault_code = code_q;

endmodule
